// File: rtl/stump_io_pkg.sv
// Shared definitions for the Stump memory-mapped I/O port: register offsets,
// status bit positions, FIFO reset values and the sticky-flag helper.
package stump_io_pkg;

  typedef enum logic {
    IO_DATA   = 1'b0,
    IO_STATUS = 1'b1
  } io_reg_e;

  localparam int unsigned ST_TX_FULL  = 32'd0;
  localparam int unsigned ST_TX_EMPTY = 32'd1;
  localparam int unsigned ST_RX_FULL  = 32'd2;
  localparam int unsigned ST_RX_EMPTY = 32'd3;
  localparam int unsigned ST_TX_OVR   = 32'd4;
  localparam int unsigned ST_RX_UDR   = 32'd5;
  localparam int unsigned ST_TX_CNT   = 32'd8;
  localparam int unsigned ST_RX_CNT   = 32'd12;

  localparam logic [15:0] FIFO_RST_DATA = 16'h0000;
  localparam logic [15:0] STATUS_RST    = 16'h0000;

  // Set has priority over write-1-to-clear.
  function automatic logic sticky_next(input logic cur, input logic set, input logic clr);
    return set | (cur & ~clr);
  endfunction

endpackage

// File: rtl/stump_io_fifo.sv
// Synchronous FIFO without fall-through: full/empty come from the count at the
// start of the cycle, so a push into a full FIFO is refused even when popping.
module stump_io_fifo
  import stump_io_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       din,
  output logic [WIDTH-1:0]       head,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PW-1:0]    wr_ptr_r;
  logic [PW-1:0]    rd_ptr_r;
  logic [CW-1:0]    count_r;
  logic             do_push_s;
  logic             do_pop_s;

  assign full      = (count_r == CNT_FULL);
  assign empty     = (count_r == {CW{1'b0}});
  assign count     = count_r;
  assign do_push_s = push & ~full;
  assign do_pop_s  = pop & ~empty;
  assign head      = empty ? FIFO_RST_DATA[WIDTH-1:0] : mem_r[rd_ptr_r];

  // Storage array; contents are don't-care while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (!rst && do_push_s) begin
      mem_r[wr_ptr_r] <= din;
    end
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (do_push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/stump_io_port.sv
// Stump memory-mapped I/O port: DATA/STATUS window, TX and RX FIFOs.
// Optional sticky error flags are enabled by defining STUMP_IO_STICKY_ERR_EN.
module stump_io_port
  import stump_io_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR = 16'hFF00,
  parameter int          DEPTH     = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] address,
  input  logic [15:0] data_out,
  input  logic        mem_wen,
  input  logic        mem_ren,
  output logic        io_sel,
  output logic [15:0] io_rdata,
  output logic [15:0] tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [15:0] rx_data,
  input  logic        rx_valid,
  output logic        rx_ready
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic          tx_wr_s;
  logic          rx_rd_s;
  logic          tx_full_s;
  logic          tx_empty_s;
  logic          rx_full_s;
  logic          rx_empty_s;
  logic [CW-1:0] tx_count_s;
  logic [CW-1:0] rx_count_s;
  logic [15:0]   rx_head_s;
  logic [15:0]   status_s;
  logic [1:0]    sticky_s;
  logic          ready_en_r;

  assign io_sel = (address[15:1] == BASE_ADDR[15:1]);
  // A combined write+read is treated as a write only; the read never pops.
  assign tx_wr_s = io_sel & mem_wen & (address[0] == IO_DATA);
  assign rx_rd_s = io_sel & mem_ren & ~mem_wen & (address[0] == IO_DATA);

  assign tx_valid = ~tx_empty_s & ~rst;
  assign rx_ready = ready_en_r & ~rst & ~rx_full_s;

  // Holds off the source for the first cycle after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      ready_en_r <= 1'b0;
    end else begin
      ready_en_r <= 1'b1;
    end
  end

  stump_io_fifo #(
    .WIDTH (16),
    .DEPTH (DEPTH)
  ) u_tx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (tx_wr_s),
    .pop   (tx_valid & tx_ready),
    .din   (data_out),
    .head  (tx_data),
    .full  (tx_full_s),
    .empty (tx_empty_s),
    .count (tx_count_s)
  );

  stump_io_fifo #(
    .WIDTH (16),
    .DEPTH (DEPTH)
  ) u_rx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (rx_valid & rx_ready),
    .pop   (rx_rd_s),
    .din   (rx_data),
    .head  (rx_head_s),
    .full  (rx_full_s),
    .empty (rx_empty_s),
    .count (rx_count_s)
  );

`ifdef STUMP_IO_STICKY_ERR_EN
  logic tx_ovr_r;
  logic rx_udr_r;
  logic stat_wr_s;

  assign stat_wr_s = io_sel & mem_wen & (address[0] == IO_STATUS);

  // Error flags: set on dropped write / empty read, cleared by STATUS write-1.
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_ovr_r <= 1'b0;
      rx_udr_r <= 1'b0;
    end else begin
      tx_ovr_r <= sticky_next(tx_ovr_r, tx_wr_s & tx_full_s, stat_wr_s & data_out[ST_TX_OVR]);
      rx_udr_r <= sticky_next(rx_udr_r, rx_rd_s & rx_empty_s, stat_wr_s & data_out[ST_RX_UDR]);
    end
  end

  assign sticky_s = {rx_udr_r, tx_ovr_r};
`else
  assign sticky_s = 2'b00;
`endif

  // Status word assembly.
  always_comb begin
    status_s                  = STATUS_RST;
    status_s[ST_TX_FULL]      = tx_full_s;
    status_s[ST_TX_EMPTY]     = tx_empty_s;
    status_s[ST_RX_FULL]      = rx_full_s;
    status_s[ST_RX_EMPTY]     = rx_empty_s;
    status_s[ST_TX_OVR]       = sticky_s[0];
    status_s[ST_RX_UDR]       = sticky_s[1];
    status_s[ST_TX_CNT +: 4]  = 4'(tx_count_s);
    status_s[ST_RX_CNT +: 4]  = 4'(rx_count_s);
  end

  // CPU read mux, combinational in the access cycle.
  always_comb begin
    io_rdata = 16'h0000;
    if (io_sel && mem_ren) begin
      case (io_reg_e'(address[0]))
        IO_DATA:   io_rdata = rx_head_s;
        IO_STATUS: io_rdata = status_s;
        default:   io_rdata = 16'h0000;
      endcase
    end else begin
      io_rdata = 16'h0000;
    end
  end

endmodule

// File: tb/tb_stump_io_port.sv
// Self-checking bench for stump_io_port: queue scoreboards for the TX and RX
// paths plus directed status checks; honours STUMP_IO_STICKY_ERR_EN.
module tb_stump_io_port;

  localparam logic [15:0] BASE  = 16'hFF00;
  localparam logic [15:0] STAT  = 16'hFF01;
  localparam int          DEPTH = 4;
`ifdef STUMP_IO_STICKY_ERR_EN
  localparam bit STICKY = 1'b1;
`else
  localparam bit STICKY = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic [15:0] address;
  logic [15:0] data_out;
  logic        mem_wen;
  logic        mem_ren;
  logic        io_sel;
  logic [15:0] io_rdata;
  logic [15:0] tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [15:0] rx_data;
  logic        rx_valid;
  logic        rx_ready;

  int checks = 0;
  int errors = 0;

  logic [15:0] tx_q[$];
  logic [15:0] rx_q[$];
  bit          ovr_m;
  bit          udr_m;
  bit          rx_en_m;
  logic [15:0] rd;

  stump_io_port #(
    .BASE_ADDR (BASE),
    .DEPTH     (DEPTH)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .address  (address),
    .data_out (data_out),
    .mem_wen  (mem_wen),
    .mem_ren  (mem_ren),
    .io_sel   (io_sel),
    .io_rdata (io_rdata),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] status_m();
    logic [15:0] s;
    s        = 16'h0000;
    s[0]     = (tx_q.size() == DEPTH);
    s[1]     = (tx_q.size() == 0);
    s[2]     = (rx_q.size() == DEPTH);
    s[3]     = (rx_q.size() == 0);
    s[4]     = STICKY & ovr_m;
    s[5]     = STICKY & udr_m;
    s[11:8]  = 4'(tx_q.size());
    s[15:12] = 4'(rx_q.size());
    return s;
  endfunction

  // One bus cycle: drive at negedge, check against the model, update the model, take the edge.
  task automatic cyc(input logic wen, input logic ren, input logic [15:0] addr, input logic [15:0] wdata,
                     input logic txr, input logic rxv, input logic [15:0] rxd, output logic [15:0] rdata);
    logic        sel;
    logic        tx_full;
    logic        rx_empty;
    logic        tx_pop;
    logic        rx_push;
    logic        rx_pop;
    logic [15:0] exp_rd;
    @(negedge clk);
    mem_wen  = wen;
    mem_ren  = ren;
    address  = addr;
    data_out = wdata;
    tx_ready = txr;
    rx_valid = rxv;
    rx_data  = rxd;
    #1;
    rdata    = io_rdata;
    sel      = (addr[15:1] == BASE[15:1]);
    tx_full  = (tx_q.size() == DEPTH);
    rx_empty = (rx_q.size() == 0);
    exp_rd   = 16'h0000;
    if (sel && ren) exp_rd = addr[0] ? status_m() : (rx_empty ? 16'h0000 : rx_q[0]);
    check_eq("io_sel", 16'(io_sel), 16'(sel));
    check_eq("io_rdata", io_rdata, exp_rd);
    check_eq("tx_valid", 16'(tx_valid), 16'(tx_q.size() != 0));
    check_eq("tx_data", tx_data, (tx_q.size() != 0) ? tx_q[0] : 16'h0000);
    check_eq("rx_ready", 16'(rx_ready), 16'(rx_en_m && rx_q.size() < DEPTH));
    tx_pop  = txr && (tx_q.size() != 0);
    rx_push = rxv && rx_en_m && (rx_q.size() < DEPTH);
    rx_pop  = sel && ren && !wen && !addr[0] && !rx_empty;
    if (sel && wen && addr[0]) begin
      if (wdata[4]) ovr_m = 1'b0;
      if (wdata[5]) udr_m = 1'b0;
    end
    if (sel && ren && !wen && !addr[0] && rx_empty) udr_m = 1'b1;
    if (tx_pop) void'(tx_q.pop_front());
    if (sel && wen && !addr[0]) begin
      if (tx_full) ovr_m = 1'b1;
      else tx_q.push_back(wdata);
    end
    if (rx_pop) void'(rx_q.pop_front());
    if (rx_push) rx_q.push_back(rxd);
    rx_en_m = 1'b1;
    @(posedge clk);
  endtask

  task automatic do_reset(input logic txr, input logic rxv);
    @(negedge clk);
    rst      = 1'b1;
    mem_wen  = 1'b0;
    mem_ren  = 1'b0;
    tx_ready = txr;
    rx_valid = rxv;
    rx_data  = 16'hDEAD;
    #1;
    check_eq("rst_tx_valid", 16'(tx_valid), 16'h0000);
    check_eq("rst_rx_ready", 16'(rx_ready), 16'h0000);
    @(posedge clk);
    tx_q.delete();
    rx_q.delete();
    ovr_m   = 1'b0;
    udr_m   = 1'b0;
    rx_en_m = 1'b0;
    #1;
    rst      = 1'b0;
    tx_ready = 1'b0;
    rx_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; address = 16'h0000; data_out = 16'h0000; mem_wen = 1'b0; mem_ren = 1'b0;
    tx_ready = 1'b0; rx_valid = 1'b0; rx_data = 16'h0000;
    ovr_m = 1'b0; udr_m = 1'b0; rx_en_m = 1'b0;
    repeat (2) @(posedge clk);
    do_reset(1'b0, 1'b0);

    cyc(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, rd);
    cyc(1'b0, 1'b1, STAT, 16'h0000, 1'b0, 1'b0, 16'h0000, rd);
    check_eq("status_reset", rd, 16'h000A);

    for (int i = 1; i <= 4; i++) cyc(1'b1, 1'b0, BASE, 16'(i * 16'h1111), 1'b0, 1'b0, 16'h0000, rd);
    cyc(1'b0, 1'b1, STAT, 16'h0000, 1'b0, 1'b0, 16'h0000, rd);
    check_eq("status_tx_full", rd, 16'h0409);
    cyc(1'b1, 1'b0, BASE, 16'h5555, 1'b0, 1'b0, 16'h0000, rd);
    cyc(1'b0, 1'b1, STAT, 16'h0000, 1'b0, 1'b0, 16'h0000, rd);
    check_eq("status_tx_drop", rd, STICKY ? 16'h0419 : 16'h0409);

    for (int i = 0; i < 5; i++) cyc(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0000, rd);
    cyc(1'b0, 1'b1, STAT, 16'h0000, 1'b0, 1'b0, 16'h0000, rd);
    check_eq("status_drained", rd, STICKY ? 16'h001A : 16'h000A);

    cyc(1'b1, 1'b0, STAT, 16'h0030, 1'b0, 1'b0, 16'h0000, rd);
    cyc(1'b1, 1'b0, STAT, 16'h0030, 1'b0, 1'b0, 16'h0000, rd);
    cyc(1'b0, 1'b1, STAT, 16'h0000, 1'b0, 1'b0, 16'h0000, rd);
    check_eq("status_cleared", rd, 16'h000A);

    cyc(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1, 16'hA001, rd);
    cyc(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1, 16'hA002, rd);
    cyc(1'b0, 1'b1, BASE, 16'h0000, 1'b0, 1'b0, 16'h0000, rd);
    check_eq("rx_rd0", rd, 16'hA001);
    cyc(1'b0, 1'b1, BASE, 16'h0000, 1'b0, 1'b0, 16'h0000, rd);
    check_eq("rx_rd1", rd, 16'hA002);
    cyc(1'b0, 1'b1, BASE, 16'h0000, 1'b0, 1'b0, 16'h0000, rd);
    check_eq("rx_rd_empty", rd, 16'h0000);
    cyc(1'b0, 1'b1, STAT, 16'h0000, 1'b0, 1'b0, 16'h0000, rd);
    check_eq("status_udr", rd, STICKY ? 16'h002A : 16'h000A);

    cyc(1'b0, 1'b1, 16'hFF02, 16'h0000, 1'b0, 1'b0, 16'h0000, rd);
    check_eq("outside_window", rd, 16'h0000);

    cyc(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1, 16'hB00B, rd);
    cyc(1'b1, 1'b1, BASE, 16'h0C0C, 1'b0, 1'b0, 16'h0000, rd);
    check_eq("wr_rd_rdata", rd, 16'hB00B);
    cyc(1'b0, 1'b1, BASE, 16'h0000, 1'b0, 1'b0, 16'h0000, rd);
    check_eq("wr_rd_no_pop", rd, 16'hB00B);

    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, BASE, 16'(16'h0C0D + i), 1'b0, 1'b0, 16'h0000, rd);
    cyc(1'b1, 1'b0, BASE, 16'h0CFF, 1'b1, 1'b0, 16'h0000, rd);
    cyc(1'b0, 1'b1, STAT, 16'h0000, 1'b0, 1'b0, 16'h0000, rd);
    check_eq("status_full_pop", rd, STICKY ? 16'h0338 : 16'h0308);
    cyc(1'b1, 1'b0, STAT, 16'h0010, 1'b0, 1'b0, 16'h0000, rd);
    cyc(1'b0, 1'b1, STAT, 16'h0000, 1'b0, 1'b0, 16'h0000, rd);
    check_eq("status_clr_ovr", rd, STICKY ? 16'h0328 : 16'h0308);

    cyc(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b1, 16'hC001, rd);
    cyc(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1, 16'hC002, rd);
    cyc(1'b0, 1'b1, STAT, 16'h0000, 1'b0, 1'b0, 16'h0000, rd);
    check_eq("status_half", rd, STICKY ? 16'h2220 : 16'h2200);

    do_reset(1'b1, 1'b1);
    cyc(1'b0, 1'b1, STAT, 16'h0000, 1'b1, 1'b0, 16'h0000, rd);
    check_eq("status_after_rst", rd, 16'h000A);
    cyc(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, rd);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
